// File: rtl/seven_segment_scan.sv
// seven_segment_scan: a sequential double-dabble converter (binary to BCD)
// that drives a time-multiplexed bank of NUM_DIGITS seven-segment digits.
// Optional leading-zero blanking is enabled by defining SEVEN_SEGMENT_SCAN_LZB_EN.
module seven_segment_scan #(
    parameter int VALUE_WIDTH = 8,
    parameter int NUM_DIGITS  = 3,
    parameter int SCAN_DIV    = 1000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [VALUE_WIDTH-1:0]    value,
    output logic                      busy,
    output logic                      done,
    output logic [4*NUM_DIGITS-1:0]   bcd_out,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     digit_en
);
    localparam int BW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(VALUE_WIDTH + 1);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic {IDLE = 1'b0, CONVERT = 1'b1} state_t;

    state_t                       state, state_next;
    logic                         start, finish;
    logic [VALUE_WIDTH-1:0]       shreg;
    logic [BW-1:0]                scratch, adj;
    logic [CW-1:0]                cnt;
    logic [BW+VALUE_WIDTH-1:0]    shifted;
    logic [PW-1:0]                prescaler;
    logic [IW-1:0]                index;
    logic [NUM_DIGITS-1:0][3:0]   nibs;
    logic [3:0]                   nib_sel;
    logic                         blank;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 7'b1111110;
            4'd1:    decode = 7'b0110000;
            4'd2:    decode = 7'b1101101;
            4'd3:    decode = 7'b1111001;
            4'd4:    decode = 7'b0110011;
            4'd5:    decode = 7'b1011011;
            4'd6:    decode = 7'b1011111;
            4'd7:    decode = 7'b1110000;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1110011;
            default: decode = 7'b0000000;
        endcase
    endfunction

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM next-state and control strobes; the final shift is the one taken with cnt==1
    always_comb begin
        state_next = state;
        start      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    start      = 1'b1;
                    state_next = CONVERT;
                end
            end
            CONVERT: begin
                if (cnt == CW'(1)) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == CONVERT);

    // One double-dabble step: add 3 to every nibble >= 5, then shift the pair left
    always_comb begin
        adj = scratch;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
        shifted = {adj, shreg} << 1;
    end

    // Conversion datapath; bcd_out only changes on commit so the display never sees partial digits
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd_out <= '0;
            done    <= 1'b0;
        end else begin
            done <= finish;
            if (start) begin
                shreg   <= value;
                scratch <= '0;
                cnt     <= CW'(VALUE_WIDTH);
            end else if (state == CONVERT) begin
                {scratch, shreg} <= shifted;
                cnt              <= cnt - 1'b1;
            end
            if (finish) bcd_out <= shifted[BW+VALUE_WIDTH-1:VALUE_WIDTH];
        end
    end

    // Free-running scan: prescaler wraps every SCAN_DIV cycles and steps the digit index
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            index     <= '0;
        end else if (prescaler == PW'(SCAN_DIV - 1)) begin
            prescaler <= '0;
            index     <= (index == IW'(NUM_DIGITS - 1)) ? '0 : index + 1'b1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    assign nibs    = bcd_out;
    assign nib_sel = nibs[index];

`ifdef SEVEN_SEGMENT_SCAN_LZB_EN
    logic [NUM_DIGITS:0] lz;

    // lz[i] is set when nibble i and all higher nibbles are zero; digit 0 is never blanked
    always_comb begin
        lz             = '0;
        lz[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) lz[i] = lz[i+1] & (nibs[i] == 4'd0);
        blank = (index != '0) && lz[index];
    end
`else
    assign blank = 1'b0;
`endif

    // Registered display outputs, one cycle behind the index
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_en <= NUM_DIGITS'(1);
            seg      <= 7'b1111110;
        end else begin
            digit_en <= NUM_DIGITS'(1) << index;
            seg      <= blank ? 7'b0000000 : decode(nib_sel);
        end
    end
endmodule

// File: tb/tb_seven_segment_scan.sv
// Self-checking bench for seven_segment_scan: a 3-digit/8-bit instance and a
// 4-digit/10-bit instance, both with a 4-cycle scan period.
module tb_seven_segment_scan;
    logic        clk = 1'b0;
    logic        reset, load, load2;
    logic [7:0]  value;
    logic [9:0]  value2;
    logic        busy, done, busy2, done2;
    logic [11:0] bcd_out;
    logic [15:0] bcd2;
    logic [6:0]  seg, seg2;
    logic [2:0]  digit_en;
    logic [3:0]  de2;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    logic [11:0] exp_q[$];
    logic [11:0] mon_exp;
    logic [6:0]  cap1[3];
    logic [6:0]  cap2[4];

`ifdef SEVEN_SEGMENT_SCAN_LZB_EN
    localparam logic LZB = 1'b1;
`else
    localparam logic LZB = 1'b0;
`endif

    always #5 clk = ~clk;

    seven_segment_scan #(.VALUE_WIDTH(8), .NUM_DIGITS(3), .SCAN_DIV(4)) dut (
        .clk(clk), .reset(reset), .load(load), .value(value), .busy(busy), .done(done),
        .bcd_out(bcd_out), .seg(seg), .digit_en(digit_en));

    seven_segment_scan #(.VALUE_WIDTH(10), .NUM_DIGITS(4), .SCAN_DIV(4)) dut2 (
        .clk(clk), .reset(reset), .load(load2), .value(value2), .busy(busy2), .done(done2),
        .bcd_out(bcd2), .seg(seg2), .digit_en(de2));

    // Scoreboard: each done pulse pops the expected BCD for the 3-digit instance
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL done_unexpected: got done with bcd_out=%h, required no done", bcd_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bcd_out !== mon_exp) begin
                    bad++;
                    $display("FAIL bcd_commit: got %h required %h", bcd_out, mon_exp);
                end
            end
        end
    end

    task automatic scan1();
        for (int d = 0; d < 3; d++) cap1[d] = 7'bx;
        repeat (3 * 4 + 2) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) if (digit_en == 3'(1 << d)) cap1[d] = seg;
        end
    endtask

    task automatic scan2();
        for (int d = 0; d < 4; d++) cap2[d] = 7'bx;
        repeat (4 * 4 + 2) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) if (de2 == 4'(1 << d)) cap2[d] = seg2;
        end
    endtask

    task automatic test_reset();
        logic [2:0] e_de;
        logic [6:0] e_seg;
        int idx;
        reset = 1'b1; load = 1'b0; value = '0; load2 = 1'b0; value2 = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        total += 6;
        if (busy !== 1'b0)            begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
        if (done !== 1'b0)            begin bad++; $display("FAIL reset_done: got %b required 0", done); end
        if (bcd_out !== 12'h000)      begin bad++; $display("FAIL reset_bcd: got %h required 000", bcd_out); end
        if (digit_en !== 3'b001)      begin bad++; $display("FAIL reset_digit_en: got %b required 001", digit_en); end
        if (seg !== 7'b1111110)       begin bad++; $display("FAIL reset_seg: got %b required 1111110", seg); end
        if (bcd2 !== 16'h0000)        begin bad++; $display("FAIL reset_bcd2: got %h required 0000", bcd2); end
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            idx   = ((j - 1) / 4) % 3;
            e_de  = 3'(1 << idx);
            e_seg = (LZB && idx > 0) ? 7'b0000000 : 7'b1111110;
            total += 2;
            if (digit_en !== e_de) begin bad++; $display("FAIL scan_digit_en[%0d]: got %b required %b", j, digit_en, e_de); end
            if (seg !== e_seg)     begin bad++; $display("FAIL scan_seg[%0d]: got %b required %b", j, seg, e_seg); end
        end
    endtask

    task automatic test_load();
        load = 1'b1; value = 8'd255;
        exp_q.push_back(12'h255);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            load = 1'b0;
            total += 2;
            if (busy !== (k < 8)) begin bad++; $display("FAIL load_busy[%0d]: got %b required %b", k, busy, k < 8); end
            if (done !== (k == 8)) begin bad++; $display("FAIL load_done[%0d]: got %b required %b", k, done, k == 8); end
        end
        @(negedge clk);
        scan1();
        total += 3;
        if (cap1[2] !== 7'b1101101) begin bad++; $display("FAIL load_seg_d2: got %b required 1101101", cap1[2]); end
        if (cap1[1] !== 7'b1011011) begin bad++; $display("FAIL load_seg_d1: got %b required 1011011", cap1[1]); end
        if (cap1[0] !== 7'b1011011) begin bad++; $display("FAIL load_seg_d0: got %b required 1011011", cap1[0]); end
    endtask

    task automatic test_lzb();
        int n = 0;
        logic [6:0] e_hi;
        e_hi = LZB ? 7'b0000000 : 7'b1111110;
        load = 1'b1; value = 8'd7;
        exp_q.push_back(12'h007);
        @(negedge clk);
        load = 1'b0;
        while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL lzb_timeout: got no done within 20 cycles, required done"); end
        @(negedge clk);
        scan1();
        total += 3;
        if (cap1[2] !== e_hi)       begin bad++; $display("FAIL lzb_seg_d2: got %b required %b", cap1[2], e_hi); end
        if (cap1[1] !== e_hi)       begin bad++; $display("FAIL lzb_seg_d1: got %b required %b", cap1[1], e_hi); end
        if (cap1[0] !== 7'b1110000) begin bad++; $display("FAIL lzb_seg_d0: got %b required 1110000", cap1[0]); end
    endtask

    task automatic test_back_to_back();
        int start_cnt = done_cnt;
        int n = 0;
        load = 1'b1; value = 8'd100;
        exp_q.push_back(12'h100);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            value = 8'd42;
            total++;
            if (done !== (k == 8)) begin bad++; $display("FAIL b2b_done[%0d]: got %b required %b", k, done, k == 8); end
            if (k == 8) exp_q.push_back(12'h042);
        end
        @(negedge clk);
        load = 1'b0;
        total += 2;
        if (busy !== 1'b1)     begin bad++; $display("FAIL b2b_accept_on_done: got busy=%b required 1", busy); end
        if (bcd_out !== 12'h100) begin bad++; $display("FAIL b2b_hold: got %h required 100", bcd_out); end
        while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL b2b_timeout: got no done within 20 cycles, required done"); end
        repeat (3) @(negedge clk);
        total++;
        if (done_cnt - start_cnt !== 2) begin bad++; $display("FAIL b2b_done_count: got %0d required 2", done_cnt - start_cnt); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        load = 1'b1; value = 8'd200;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total += 5;
        if (busy !== 1'b0)       begin bad++; $display("FAIL mid_busy: got %b required 0", busy); end
        if (done !== 1'b0)       begin bad++; $display("FAIL mid_done: got %b required 0", done); end
        if (bcd_out !== 12'h000) begin bad++; $display("FAIL mid_bcd: got %h required 000", bcd_out); end
        if (digit_en !== 3'b001) begin bad++; $display("FAIL mid_digit_en: got %b required 001", digit_en); end
        if (seg !== 7'b1111110)  begin bad++; $display("FAIL mid_seg: got %b required 1111110", seg); end
        repeat (15) begin @(negedge clk); if (done === 1'b1) seen++; end
        total++;
        if (seen != 0) begin bad++; $display("FAIL mid_no_done: got %0d pulses required 0", seen); end
    endtask

    task automatic test_boundary();
        logic [6:0] e_hi;
        e_hi = LZB ? 7'b0000000 : 7'b1111110;
        load2 = 1'b1; value2 = 10'd1023;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            load2 = 1'b0;
            total += 2;
            if (busy2 !== (k < 10)) begin bad++; $display("FAIL bnd_busy[%0d]: got %b required %b", k, busy2, k < 10); end
            if (done2 !== (k == 10)) begin bad++; $display("FAIL bnd_done[%0d]: got %b required %b", k, done2, k == 10); end
        end
        total++;
        if (bcd2 !== 16'h1023) begin bad++; $display("FAIL bnd_bcd_1023: got %h required 1023", bcd2); end
        load2 = 1'b1; value2 = 10'd0;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            load2 = 1'b0;
            total++;
            if (done2 !== (k == 10)) begin bad++; $display("FAIL bnd0_done[%0d]: got %b required %b", k, done2, k == 10); end
        end
        total++;
        if (bcd2 !== 16'h0000) begin bad++; $display("FAIL bnd_bcd_0: got %h required 0000", bcd2); end
        @(negedge clk);
        scan2();
        total += 4;
        if (cap2[0] !== 7'b1111110) begin bad++; $display("FAIL bnd_seg_d0: got %b required 1111110", cap2[0]); end
        for (int d = 1; d < 4; d++)
            if (cap2[d] !== e_hi) begin bad++; $display("FAIL bnd_seg_d%0d: got %b required %b", d, cap2[d], e_hi); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_lzb();
        test_back_to_back();
        test_reset_mid();
        test_boundary();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got no completion by time limit, required finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
